// File: rtl/issue_queue_if.sv
// Dispatch, writeback-snoop and issue signals of the issue queue, bundled so the
// queue and its neighbours share one port list.
interface issue_queue_if #(
  parameter int DEPTH         = 8,
  parameter int TAG_WIDTH     = 6,
  parameter int PAYLOAD_WIDTH = 105
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Dispatch handshake: an entry transfers on a clock edge where disp_valid and
  // disp_ready are both 1; disp_ready never depends on disp_valid.
  logic                     disp_valid;
  logic                     disp_ready;
  logic [PAYLOAD_WIDTH-1:0] disp_payload;
  logic [TAG_WIDTH-1:0]     disp_src1_tag;
  logic                     disp_src1_rdy;
  logic [TAG_WIDTH-1:0]     disp_src2_tag;
  logic                     disp_src2_rdy;

  logic                     wb_flag;
  logic [TAG_WIDTH-1:0]     wb_index;

  logic                     issue_valid;
  logic [PAYLOAD_WIDTH-1:0] issue_payload;
  logic [TAG_WIDTH-1:0]     issue_src1_tag;
  logic [TAG_WIDTH-1:0]     issue_src2_tag;
  logic [CNT_W-1:0]         count;
  logic                     full;

  modport slave (
    input  disp_valid, disp_payload, disp_src1_tag, disp_src1_rdy,
           disp_src2_tag, disp_src2_rdy, wb_flag, wb_index,
    output disp_ready, issue_valid, issue_payload, issue_src1_tag,
           issue_src2_tag, count, full
  );

  modport master (
    output disp_valid, disp_payload, disp_src1_tag, disp_src1_rdy,
           disp_src2_tag, disp_src2_rdy, wb_flag, wb_index,
    input  disp_ready, issue_valid, issue_payload, issue_src1_tag,
           issue_src2_tag, count, full
  );
endinterface

// File: rtl/issue_queue.sv
// Collapsing issue queue: slot 0 is oldest, operands wake up from the writeback
// broadcast, and the oldest ready entry is registered to register-read each cycle.
module issue_queue #(
  parameter int DEPTH         = 8,
  parameter int TAG_WIDTH     = 6,
  parameter int PAYLOAD_WIDTH = 105
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          FREEZE,
  input  logic          FLUSH,
  issue_queue_if.slave  iq
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic [PAYLOAD_WIDTH-1:0] payload;
    logic [TAG_WIDTH-1:0]     src1_tag;
    logic                     src1_rdy;
    logic [TAG_WIDTH-1:0]     src2_tag;
    logic                     src2_rdy;
  } entry_t;

  entry_t                   slot_q [DEPTH];
  entry_t                   slot_d [DEPTH];
  logic [DEPTH-1:0]         valid_q, valid_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic                     issue_valid_q, issue_valid_d;
  logic [PAYLOAD_WIDTH-1:0] issue_payload_q, issue_payload_d;
  logic [TAG_WIDTH-1:0]     issue_src1_tag_q, issue_src1_tag_d;
  logic [TAG_WIDTH-1:0]     issue_src2_tag_q, issue_src2_tag_d;

  logic [DEPTH-1:0] cand;
  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic             issue_fire;
  logic             accept;
  logic             full;
  logic             disp_ready;
  logic [CNT_W-1:0] wr_idx;
  entry_t           new_entry;

  function automatic entry_t wake(entry_t e, logic flag, logic [TAG_WIDTH-1:0] idx);
    entry_t r;
    r = e;
    if (flag && (e.src1_tag == idx)) r.src1_rdy = 1'b1;
    if (flag && (e.src2_tag == idx)) r.src2_rdy = 1'b1;
    return r;
  endfunction

  assign full       = (count_q == CNT_W'(DEPTH));
  // Conservative: a full queue refuses dispatch even if an issue frees a slot now.
  assign disp_ready = !full && !FREEZE && !FLUSH;
  assign accept     = iq.disp_valid && disp_ready;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cand[i] = valid_q[i] && slot_q[i].src1_rdy && slot_q[i].src2_rdy;
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (cand[i]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(i);
      end
    end
  end

  assign issue_fire = !FREEZE && !FLUSH && win_found;
  assign wr_idx     = count_q - CNT_W'(issue_fire);

  always_comb begin
    new_entry.payload  = iq.disp_payload;
    new_entry.src1_tag = iq.disp_src1_tag;
    new_entry.src1_rdy = iq.disp_src1_rdy;
    new_entry.src2_tag = iq.disp_src2_tag;
    new_entry.src2_rdy = iq.disp_src2_rdy;
  end

  always_comb begin
    valid_d          = valid_q;
    count_d          = count_q;
    issue_valid_d    = issue_valid_q;
    issue_payload_d  = issue_payload_q;
    issue_src1_tag_d = issue_src1_tag_q;
    issue_src2_tag_d = issue_src2_tag_q;
    for (int i = 0; i < DEPTH; i++) slot_d[i] = slot_q[i];

    // Compaction above the winner, with wakeup applied on the way down.
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (issue_fire && (i >= int'(win_idx))) begin
        slot_d[i]  = wake(slot_q[i+1], iq.wb_flag, iq.wb_index);
        valid_d[i] = valid_q[i+1];
      end else begin
        slot_d[i]  = wake(slot_q[i], iq.wb_flag, iq.wb_index);
        valid_d[i] = valid_q[i];
      end
    end
    slot_d[DEPTH-1]  = wake(slot_q[DEPTH-1], iq.wb_flag, iq.wb_index);
    valid_d[DEPTH-1] = issue_fire ? 1'b0 : valid_q[DEPTH-1];

    if (accept) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_idx == CNT_W'(i)) begin
          slot_d[i]  = wake(new_entry, iq.wb_flag, iq.wb_index);
          valid_d[i] = 1'b1;
        end
      end
    end

    count_d = count_q + CNT_W'(accept) - CNT_W'(issue_fire);

    if (FLUSH) begin
      valid_d       = '0;
      count_d       = '0;
      issue_valid_d = 1'b0;
    end else if (!FREEZE) begin
      issue_valid_d = win_found;
      if (win_found) begin
        issue_payload_d  = slot_q[win_idx].payload;
        issue_src1_tag_d = slot_q[win_idx].src1_tag;
        issue_src2_tag_d = slot_q[win_idx].src2_tag;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      valid_q          <= '0;
      count_q          <= '0;
      issue_valid_q    <= 1'b0;
      issue_payload_q  <= '0;
      issue_src1_tag_q <= '0;
      issue_src2_tag_q <= '0;
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
    end else begin
      valid_q          <= valid_d;
      count_q          <= count_d;
      issue_valid_q    <= issue_valid_d;
      issue_payload_q  <= issue_payload_d;
      issue_src1_tag_q <= issue_src1_tag_d;
      issue_src2_tag_q <= issue_src2_tag_d;
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= slot_d[i];
    end
  end

  assign iq.disp_ready     = disp_ready;
  assign iq.full           = full;
  assign iq.count          = count_q;
  assign iq.issue_valid    = issue_valid_q;
  assign iq.issue_payload  = issue_payload_q;
  assign iq.issue_src1_tag = issue_src1_tag_q;
  assign iq.issue_src2_tag = issue_src2_tag_q;
endmodule

// File: tb/tb_issue_queue.sv
// Bench for issue_queue: directed scenarios plus random traffic, checked against
// an age-ordered list model through an expected-output scoreboard.
module tb_issue_queue;
  localparam int DEPTH = 8;
  localparam int TW    = 6;
  localparam int PW    = 105;
  localparam int OW    = 1 + PW + 2 * TW;

  typedef struct {
    logic [PW-1:0] pl;
    logic [TW-1:0] t1;
    logic          r1;
    logic [TW-1:0] t2;
    logic          r2;
  } ent_t;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  logic FREEZE = 1'b0;
  logic FLUSH = 1'b0;

  issue_queue_if #(.DEPTH(DEPTH), .TAG_WIDTH(TW), .PAYLOAD_WIDTH(PW)) iq ();

  issue_queue #(.DEPTH(DEPTH), .TAG_WIDTH(TW), .PAYLOAD_WIDTH(PW)) dut (
    .CLK(CLK), .RESET(RESET), .FREEZE(FREEZE), .FLUSH(FLUSH), .iq(iq)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  ent_t          mq[$];
  logic [OW-1:0] m_out = '0;
  logic [OW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one clock edge on an age-ordered list of entries.
  task automatic model_edge(input logic fz, input logic fl, input logic dv, input ent_t ne,
                            input logic wbf, input logic [TW-1:0] wbi);
    logic acc;
    int   k;
    acc = dv && !fz && !fl && (mq.size() < DEPTH);
    if (fl) begin
      mq.delete();
      m_out[OW-1] = 1'b0;
    end else if (!fz) begin
      k = -1;
      for (int i = 0; i < mq.size(); i++)
        if (k < 0 && mq[i].r1 && mq[i].r2) k = i;
      if (k >= 0) begin
        m_out = {1'b1, mq[k].pl, mq[k].t1, mq[k].t2};
        mq.delete(k);
      end else begin
        m_out[OW-1] = 1'b0;
      end
    end
    if (wbf) begin
      for (int i = 0; i < mq.size(); i++) begin
        if (mq[i].t1 == wbi) mq[i].r1 = 1'b1;
        if (mq[i].t2 == wbi) mq[i].r2 = 1'b1;
      end
    end
    if (acc) begin
      if (wbf && ne.t1 == wbi) ne.r1 = 1'b1;
      if (wbf && ne.t2 == wbi) ne.r2 = 1'b1;
      mq.push_back(ne);
    end
    exp_q.push_back(m_out);
  endtask

  // driver: called at posedge+1, returns at the next posedge+1
  task automatic step(input logic fz, input logic fl, input logic dv, input logic [PW-1:0] pl,
                      input logic [TW-1:0] t1, input logic r1, input logic [TW-1:0] t2,
                      input logic r2, input logic wbf, input logic [TW-1:0] wbi);
    ent_t ne;
    FREEZE           = fz;
    FLUSH            = fl;
    iq.disp_valid    = dv;
    iq.disp_payload  = pl;
    iq.disp_src1_tag = t1;
    iq.disp_src1_rdy = r1;
    iq.disp_src2_tag = t2;
    iq.disp_src2_rdy = r2;
    iq.wb_flag       = wbf;
    iq.wb_index      = wbi;
    #1;
    chk("disp_ready", iq.disp_ready, (mq.size() < DEPTH) && !fz && !fl);
    ne.pl = pl; ne.t1 = t1; ne.r1 = r1; ne.t2 = t2; ne.r2 = r2;
    model_edge(fz, fl, dv, ne, wbf, wbi);
    @(posedge CLK);
    #1;
    chk("count", iq.count, mq.size());
    chk("full", iq.full, mq.size() == DEPTH);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0, 0, '0, 0, 0, '0);
  endtask

  task automatic disp(input logic [PW-1:0] pl, input logic [TW-1:0] t1, input logic r1,
                      input logic [TW-1:0] t2, input logic r2);
    step(0, 0, 1, pl, t1, r1, t2, r2, 0, '0);
  endtask

  task automatic wb(input logic [TW-1:0] wbi);
    step(0, 0, 0, '0, '0, 0, '0, 0, 1, wbi);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    #1;
    RESET = 1'b0;
    FREEZE = 1'b0; FLUSH = 1'b0;
    iq.disp_valid = 1'b0; iq.wb_flag = 1'b0;
    #1;
    chk("rst_count", iq.count, 0);
    chk("rst_full", iq.full, 0);
    chk("rst_issue_valid", iq.issue_valid, 0);
    chk("rst_payload", iq.issue_payload, 0);
    chk("rst_tags", {iq.issue_src1_tag, iq.issue_src2_tag}, 0);
    mq.delete();
    m_out = '0;
    exp_q.delete();
    @(posedge CLK);
    #1;
    RESET = 1'b1;
  endtask

  function automatic logic [PW-1:0] rand_pl();
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    return r[PW-1:0];
  endfunction

  // scoreboard monitor: one expected output per edge taken out of reset
  always begin : monitor
    logic          rst_s;
    logic [OW-1:0] act;
    @(posedge CLK);
    rst_s = RESET;
    @(negedge CLK);
    if (rst_s) begin
      act = {iq.issue_valid, iq.issue_payload, iq.issue_src1_tag, iq.issue_src2_tag};
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL issue_out: got %h expected nothing (queue empty) at %0t", act, $time);
      end else begin
        chk("issue_out", act, exp_q.pop_front());
      end
    end
  end

  initial begin
    iq.disp_valid = 0; iq.disp_payload = '0;
    iq.disp_src1_tag = '0; iq.disp_src1_rdy = 0;
    iq.disp_src2_tag = '0; iq.disp_src2_rdy = 0;
    iq.wb_flag = 0; iq.wb_index = '0;
    do_reset();

    // single ready entry issues one edge after acceptance
    disp(PW'(105'hA0A), 6'd5, 1, 6'd7, 1);
    idle(2);

    // younger ready entry overtakes; wakeup of the older one
    disp(PW'(105'hA1), 6'd3, 1, 6'd9, 0);
    disp(PW'(105'hB1), 6'd4, 1, 6'd6, 1);
    idle(1);
    wb(6'd9);
    idle(2);

    // dispatch coinciding with matching broadcast
    step(0, 0, 1, PW'(105'hC1), 6'd12, 0, 6'd13, 1, 1, 6'd12);
    idle(2);

    // fill, blocked dispatch, wake slot 3, drain
    for (int i = 0; i < DEPTH; i++) disp(PW'(105'h100 + i), TW'(20 + i), 0, 6'd1, 1);
    disp(PW'(105'hDEAD), 6'd2, 1, 6'd2, 1);
    wb(6'd23);
    idle(2);
    for (int i = 0; i < DEPTH; i++) if (i != 3) wb(TW'(20 + i));
    idle(3);

    // freeze with ready entries and a broadcast
    disp(PW'(105'hE1), 6'd1, 1, 6'd2, 1);
    disp(PW'(105'hE2), 6'd1, 1, 6'd2, 1);
    disp(PW'(105'hE3), 6'd40, 0, 6'd2, 1);
    step(1, 0, 1, PW'(105'hE4), 6'd1, 1, 6'd1, 1, 0, '0);
    step(1, 0, 0, '0, '0, 0, '0, 0, 1, 6'd40);
    step(1, 0, 0, '0, '0, 0, '0, 0, 0, '0);
    idle(4);

    // flush with issue_valid high and a simultaneous dispatch
    for (int i = 0; i < 5; i++) disp(PW'(105'h200 + i), TW'(50 + i), 0, 6'd1, 1);
    disp(PW'(105'h2FF), 6'd1, 1, 6'd1, 1);
    idle(1);
    step(0, 1, 1, PW'(105'h3AA), 6'd1, 1, 6'd1, 1, 0, '0);
    step(1, 1, 1, PW'(105'h3AB), 6'd1, 1, 6'd1, 1, 0, '0);
    idle(2);

    // reset mid-fill
    for (int i = 0; i < 3; i++) disp(PW'(105'h400 + i), TW'(i), 1, 6'd60, 0);
    do_reset();
    idle(2);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 99) < 12, $urandom_range(0, 99) < 2,
           $urandom_range(0, 99) < 60, rand_pl(),
           TW'($urandom_range(0, 15)), $urandom_range(0, 99) < 40,
           TW'($urandom_range(0, 15)), $urandom_range(0, 99) < 40,
           $urandom_range(0, 99) < 45, TW'($urandom_range(0, 15)));
    end
    for (int i = 0; i < 16; i++) wb(TW'(i));
    idle(DEPTH + 2);

    @(negedge CLK);
    #1;
    chk("scoreboard_drained", 128'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
